// File: rtl/video_clk_pkg.sv
// video_clk_pkg: shared state encoding, timing defaults and width helper for the video clock domain
package video_clk_pkg;

    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, QUALIFY, RUN, FAULT} state_t;

    localparam int REFCLK_HZ        = 50_000_000;
    localparam int LOCK_TIMEOUT_1MS = REFCLK_HZ / 1000;

    function automatic int clog2w(input int v);
        int w = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << w) < v) w = i + 1;
        return w;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync: multi-flop synchroniser for a single asynchronous level
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk)
        if (rst) ff <= '0;
        else     ff <= {ff[SYNC_STAGES-2:0], d};

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, qualifies lock and gates the pixel-domain reset
module pll_lock_supervisor
    import video_clk_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_1MS,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             retry,
    output logic             pll_rst,
    output logic             video_reset,
    output logic             lock_ok,
    output logic             fault,
    output logic [CNT_W-1:0] loss_count
);

    localparam int CMAX = (RST_CYCLES > LOCK_TIMEOUT)
                        ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
                        : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    localparam int CW = clog2w(CMAX);
    localparam int RW = clog2w(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    // the WAIT_LOCK cycle that first sees lock already counts as one stable cycle
    localparam logic [CW-1:0] QUAL_START   = CW'((STABLE_CYCLES > 1) ? 1 : 0);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [RW-1:0]    retries, retries_n;
    logic [CNT_W-1:0] loss_n;
    logic             locked_s, pll_rst_n, video_reset_n, lock_ok_n, fault_n;

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(refclk),
        .rst(rst),
        .d  (pll_locked),
        .q  (locked_s)
    );

    always_ff @(posedge refclk)
        if (rst) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            retries     <= '0;
            loss_count  <= '0;
            pll_rst     <= 1'b1;
            video_reset <= 1'b1;
            lock_ok     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            retries     <= retries_n;
            loss_count  <= loss_n;
            pll_rst     <= pll_rst_n;
            video_reset <= video_reset_n;
            lock_ok     <= lock_ok_n;
            fault       <= fault_n;
        end

    always_comb begin
        state_n   = state;
        cnt_n     = '0;
        retries_n = retries;
        loss_n    = loss_count;
        case (state)
            RESET_PLL:
                if (cnt == RST_LAST) state_n = WAIT_LOCK;
                else                 cnt_n   = cnt + 1'b1;
            WAIT_LOCK:
                if (locked_s) begin
                    state_n = QUALIFY;
                    cnt_n   = QUAL_START;
                end else if (cnt == TIMEOUT_LAST) begin
                    retries_n = retries + 1'b1;
                    state_n   = (retries_n == RETRY_LIMIT) ? FAULT : RESET_PLL;
                end else cnt_n = cnt + 1'b1;
            QUALIFY:
                if (!locked_s) state_n = WAIT_LOCK;
                else if (cnt == STABLE_LAST) begin
                    state_n   = RUN;
                    retries_n = '0;
                end else cnt_n = cnt + 1'b1;
            RUN:
                if (!locked_s) begin
                    state_n = RESET_PLL;
                    loss_n  = (&loss_count) ? loss_count : loss_count + 1'b1;
                end
            FAULT:
                if (retry) begin
                    state_n   = RESET_PLL;
                    retries_n = '0;
                end
            default: state_n = RESET_PLL;
        endcase
    end

    always_comb begin
        pll_rst_n     = (state_n == RESET_PLL) || (state_n == FAULT);
        video_reset_n = state_n != RUN;
        lock_ok_n     = state_n == RUN;
        fault_n       = state_n == FAULT;
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed checks of bring-up, glitch, timeout/fault, loss and reset paths
module tb_pll_lock_supervisor;

    logic       refclk = 0, rst = 1, pll_locked = 0, retry = 0;
    logic       pll_rst, video_reset, lock_ok, fault;
    logic [1:0] loss_count;
    int         n_chk = 0, n_fail = 0, hi, mx;

    pll_lock_supervisor #(
        .SYNC_STAGES(2), .RST_CYCLES(4), .LOCK_TIMEOUT(20),
        .STABLE_CYCLES(8), .MAX_RETRIES(3), .CNT_W(2)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .retry(retry),
        .pll_rst(pll_rst), .video_reset(video_reset), .lock_ok(lock_ok),
        .fault(fault), .loss_count(loss_count)
    );

    always #5 refclk = ~refclk;

    task automatic tick;
        @(negedge refclk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // holds rst for three edges, checks reset outputs, releases rst on a falling edge
    task automatic do_reset(input logic locked);
        tick;
        rst = 1; pll_locked = locked; retry = 0;
        repeat (3) tick;
        check("rst_pll_rst", pll_rst, 1);
        check("rst_video_reset", video_reset, 1);
        check("rst_lock_ok", lock_ok, 0);
        check("rst_fault", fault, 0);
        check("rst_loss", loss_count, 0);
        rst = 0;
    endtask

    task automatic wait_lock;
        for (int i = 0; i < 60 && !lock_ok; i++) tick;
        check("wait_lock", lock_ok, 1);
    endtask

    initial begin
        // bring-up
        do_reset(0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin hi += pll_rst; tick; end
        check("t1_rst_len", hi, 4);
        pll_locked = 1;
        repeat (9) tick;
        check("t1_vr_hold", video_reset, 1);
        tick;
        check("t1_vr_fall", video_reset, 0);
        check("t1_lock_ok", lock_ok, 1);
        check("t1_pll_rst", pll_rst, 0);
        check("t1_loss", loss_count, 0);

        // repeated lock loss, saturating counter; the last pass rolls into a mid-QUALIFY reset
        for (int i = 1; i <= 4; i++) begin
            pll_locked = 0;
            repeat (2) tick;
            check("t4_vr_early", video_reset, 0);
            tick;
            check("t4_vr_rise", video_reset, 1);
            check("t4_pll_rst", pll_rst, 1);
            check("t4_lock_ok", lock_ok, 0);
            check("t4_loss", loss_count, (i < 3) ? i : 3);
            pll_locked = 1;
            if (i < 4) wait_lock;
        end
        repeat (9) tick;
        check("t5_in_qualify", video_reset, 1);
        check("t5_pll_rst_low", pll_rst, 0);
        rst = 1;
        tick;
        rst = 0;
        check("t5_pll_rst", pll_rst, 1);
        check("t5_video_reset", video_reset, 1);
        check("t5_loss", loss_count, 0);
        hi = 0;
        for (int i = 0; i < 4; i++) begin hi += pll_rst; tick; end
        check("t5_rst_len", hi, 4);
        check("t5_rst_fall", pll_rst, 0);
        repeat (7) tick;
        check("t5_vr_hold", video_reset, 1);
        tick;
        check("t5_vr_fall", video_reset, 0);

        // glitch during QUALIFY
        do_reset(0);
        repeat (10) tick;
        pll_locked = 1;
        mx = 0;
        repeat (5) begin tick; mx |= pll_rst; end
        pll_locked = 0;
        tick;
        pll_locked = 1;
        repeat (9) begin tick; mx |= pll_rst; end
        check("t2_vr_hold", video_reset, 1);
        tick;
        check("t2_vr_fall", video_reset, 0);
        check("t2_no_pll_rst", mx, 0);
        check("t2_lock_ok", lock_ok, 1);

        // timeouts into FAULT, then retry
        do_reset(0);
        for (int i = 0; i < 76; i++) begin
            check("t3_pll_rst", pll_rst, (i < 4) || (i >= 24 && i < 28) || (i >= 48 && i < 52) || (i >= 72));
            check("t3_fault", fault, i >= 72);
            tick;
        end
        check("t3_vr_fault", video_reset, 1);
        retry = 1;
        tick;
        retry = 0;
        check("t3_fault_clr", fault, 0);
        hi = 0;
        for (int i = 0; i < 4; i++) begin hi += pll_rst; tick; end
        check("t3_retry_len", hi, 4);
        check("t3_retry_fall", pll_rst, 0);
        retry = 1;
        tick;
        retry = 0;
        check("t3_retry_ignored", pll_rst, 0);

        // lock arriving on the timeout cycle wins
        do_reset(0);
        repeat (21) tick;
        pll_locked = 1;
        mx = 0;
        repeat (9) begin tick; mx |= pll_rst; end
        check("t6_vr_hold", video_reset, 1);
        tick;
        check("t6_vr_fall", video_reset, 0);
        check("t6_no_pll_rst", mx, 0);
        check("t6_lock_ok", lock_ok, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
